// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
// Optional feature macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN (consumed by countdown_timer).
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_e;

   localparam int unsigned DEF_N        = 8;
   localparam int unsigned DEF_PRESCALE = 100_000_000;

   // A prescale of 1 still needs a one-bit counter.
   function automatic int unsigned pw_for(input int unsigned prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Mod-PRESCALE counter; tick is high while the count sits at PRESCALE-1.
module tick_prescaler #(
   parameter int unsigned PRESCALE = 4,
   parameter int unsigned PW       = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   logic [PW-1:0] count_q, count_d;

   assign tick = (count_q == PW'(PRESCALE - 1));

   always_comb begin
      // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = tick ? '0 : count_q + PW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaler, start/pause/resume and done/expired flags.
// Define COUNTDOWN_TIMER_AUTO_RELOAD_EN to reload from the load value instead of expiring.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned N        = DEF_N,
   parameter int unsigned PRESCALE = DEF_PRESCALE,
   parameter int unsigned PW       = pw_for(PRESCALE)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         start,
   input  logic         pause,
   output logic [N-1:0] q,
   output logic         running,
   output logic         expired,
   output logic         done
);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
   localparam state_e TERM_STATE     = RUN;
   localparam logic   RELOAD_ON_TERM = 1'b1;
`else
   localparam state_e TERM_STATE     = EXPIRED;
   localparam logic   RELOAD_ON_TERM = 1'b0;
`endif

   state_e       state_q, state_d;
   logic [N-1:0] q_q, q_d;
   logic [N-1:0] reload_q, reload_d;
   logic         done_q, done_d;
   logic         presc_en, presc_clr, tick;
   logic         step, last;

   tick_prescaler #(
      .PRESCALE (PRESCALE),
      .PW       (PW)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (presc_en),
      .clr  (presc_clr),
      .tick (tick)
   );

   assign step = presc_en && tick;
   assign last = (q_q == N'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start && (q_q != '0)) state_d = RUN;
            RUN: begin
               if (pause)              state_d = PAUSED;
               else if (step && last)  state_d = TERM_STATE;
            end
            PAUSED:  if (start) state_d = RUN;
            default: state_d = state_q;
         endcase
      end
   end

   // Pause freezes the prescaler in place, so a tick seen on a pause cycle is dropped.
   always_comb begin
      presc_en  = (state_q == RUN) && !load && !pause;
      presc_clr = load || ((state_q == IDLE) && start);
      running   = (state_q == RUN);
      expired   = (state_q == EXPIRED);
   end

   always_comb begin
      q_d      = q_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         q_d      = load_val;
         reload_d = load_val;
      end else if (step) begin
         if (last) begin
            done_d = 1'b1;
            q_d    = RELOAD_ON_TERM ? reload_q : '0;
         end else begin
            q_d = q_q - N'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q      <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         q_q      <= q_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign q    = q_q;
   assign done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic,
// all compared every cycle against a cycles-to-next-decrement reference model.
module tb_countdown_timer;

   localparam int N = 8;
   localparam int P = 4;

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic         clk      = 1'b0;
   logic         rst      = 1'b0;
   logic         load     = 1'b0;
   logic [N-1:0] load_val = '0;
   logic         start    = 1'b0;
   logic         pause    = 1'b0;
   logic [N-1:0] q;
   logic         running;
   logic         expired;
   logic         done;

   int checks = 0;
   int errors = 0;

   typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mmode_e;
   mmode_e m_mode;
   int     m_q;
   int     m_reload;
   int     m_left;   // counting cycles still needed before the next decrement
   bit     m_done;

   countdown_timer #(
      .N        (N),
      .PRESCALE (P)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .pause    (pause),
      .q        (q),
      .running  (running),
      .expired  (expired),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_q      = 0;
      m_reload = 0;
      m_left   = P;
      m_done   = 1'b0;
   endtask

   // Applies the inputs that were present at the edge just taken.
   task automatic model_step();
      m_done = 1'b0;
      if (load) begin
         m_q      = int'(load_val);
         m_reload = int'(load_val);
         m_left   = P;
         m_mode   = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE: if (start && m_q != 0) begin
               m_mode = M_RUN;
               m_left = P;
            end
            M_RUN: begin
               if (pause) begin
                  m_mode = M_PAUSED;
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_left = P;
                     if (m_q > 1) begin
                        m_q--;
                     end else begin
                        m_done = 1'b1;
                        if (AUTO) m_q = m_reload;
                        else begin
                           m_q    = 0;
                           m_mode = M_EXPIRED;
                        end
                     end
                  end
               end
            end
            M_PAUSED: if (start) m_mode = M_RUN;
            default: ;
         endcase
      end
   endtask

   task automatic check_all(input string tag);
      chk($sformatf("%s q", tag),       32'(q),       32'(m_q));
      chk($sformatf("%s running", tag), 32'(running), 32'(m_mode == M_RUN));
      chk($sformatf("%s expired", tag), 32'(expired), 32'(m_mode == M_EXPIRED));
      chk($sformatf("%s done", tag),    32'(done),    32'(m_done));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      model_step();
      check_all("cycle");
   endtask

   task automatic do_load(input int v);
      load     = 1'b1;
      load_val = N'(v);
      cyc();
      load     = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      chk("reset q zero",       32'(q),       32'd0);
      chk("reset running zero", 32'(running), 32'd0);
      chk("reset done zero",    32'(done),    32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int dn;
      bit ex;
      model_reset();
      @(posedge clk);
      #1;
      check_all("por");
      rst = 1'b1;

      // Plain countdown from 3, start sampled at edge 0.
      do_load(3);
      do_start();
      dn = 0;
      for (int e = 1; e <= 13; e++) begin
         cyc();
         dn += int'(done);
         if (e == 4)  chk("s1 q at edge 4", 32'(q), 32'd2);
         if (e == 8)  chk("s1 q at edge 8", 32'(q), 32'd1);
         if (e == 11) chk("s1 done before terminal", 32'(done), 32'd0);
         if (e == 12) begin
            chk("s1 done at edge 12", 32'(done), 32'd1);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            chk("s1 reload q at edge 12", 32'(q), 32'd3);
            chk("s1 no expiry", 32'(expired), 32'd0);
`else
            chk("s1 q at edge 12", 32'(q), 32'd0);
            chk("s1 expired at edge 12", 32'(expired), 32'd1);
            chk("s1 stopped at edge 12", 32'(running), 32'd0);
`endif
         end
      end
      chk("s1 single done pulse", 32'(dn), 32'd1);

      // Pause at edge 6, ten frozen cycles, terminal moves to edge 22.
      do_load(3);
      do_start();
      dn = 0;
      for (int e = 1; e <= 25; e++) begin
         pause = (e == 6);
         start = (e == 15);
         cyc();
         dn += int'(done);
         if (e >= 6 && e <= 15) chk($sformatf("s2 hold q edge %0d", e), 32'(q), 32'd2);
         if (e == 10) chk("s2 paused not running", 32'(running), 32'd0);
         if (e == 21) chk("s2 q at edge 21", 32'(q), 32'd1);
         if (e == 21) chk("s2 no early done", 32'(done), 32'd0);
         if (e == 22) chk("s2 done at edge 22", 32'(done), 32'd1);
      end
      pause = 1'b0;
      start = 1'b0;
      chk("s2 single done pulse", 32'(dn), 32'd1);

      // Reload mid-run.
      do_load(5);
      do_start();
      for (int e = 1; e <= 7; e++) begin
         load     = (e == 7);
         load_val = 8'd9;
         cyc();
         if (e == 4) chk("s3 q at edge 4", 32'(q), 32'd4);
      end
      load = 1'b0;
      chk("s3 q after reload", 32'(q), 32'd9);
      chk("s3 idle after reload", 32'(running), 32'd0);
      chk("s3 no done on reload", 32'(done), 32'd0);
      do_start();
      repeat (4) cyc();
      chk("s3 counts down from 9", 32'(q), 32'd8);

      // Start with zero count, then reset mid-run.
      async_reset();
      do_start();
      chk("s4 start with zero ignored", 32'(running), 32'd0);
      do_load(4);
      do_start();
      repeat (6) cyc();
      async_reset();
      repeat (8) cyc();
      chk("s4 no resume after reset", 32'(running), 32'd0);
      chk("s4 q stays zero", 32'(q), 32'd0);

      // Simultaneous controls.
      do_load(5);
      do_start();
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      chk("s5 paused", 32'(running), 32'd0);
      repeat (3) cyc();
      start = 1'b1;
      pause = 1'b1;
      cyc();
      start = 1'b0;
      pause = 1'b0;
      chk("s5 start+pause resumes", 32'(running), 32'd1);
      load     = 1'b1;
      start    = 1'b1;
      load_val = 8'd7;
      cyc();
      load  = 1'b0;
      start = 1'b0;
      chk("s5 load+start q", 32'(q), 32'd7);
      chk("s5 load+start idle", 32'(running), 32'd0);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      do_load(2);
      do_start();
      dn = 0;
      ex = 1'b0;
      for (int e = 1; e <= 24; e++) begin
         cyc();
         dn += int'(done);
         ex |= expired;
         if (e == 4) chk("ar q at edge 4", 32'(q), 32'd1);
         if (e == 8) chk("ar q reloaded at edge 8", 32'(q), 32'd2);
      end
      chk("ar done every 8 cycles", 32'(dn), 32'd3);
      chk("ar never expired", 32'(ex), 32'd0);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) < 3) begin
            async_reset();
         end else begin
            load     = ($urandom_range(0, 39) == 0);
            load_val = N'($urandom_range(0, 6));
            start    = ($urandom_range(0, 5) == 0);
            pause    = ($urandom_range(0, 9) == 0);
            cyc();
         end
      end
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting timer with an internal prescaler. It is the decrementing counterpart of the up-counting and mod counters used for 1-second and 1-minute timing. Software or button logic loads a count, then starts, pauses and resumes it. The block decrements once per prescaler period and raises a one-cycle `done` pulse and a sticky `expired` flag when the count reaches zero. It sits between the board's clock/button inputs and the display or LED drivers.

## Interface
- `N`, 8, width of the count value
- `PRESCALE`, 100_000_000, clock cycles per decrement (≥1; 100 MHz → 1 s)
- `PW`, `$clog2(PRESCALE)` (min 1), prescaler counter width
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `load`  input  1  load `load_val` into count and reload register
- `load_val`  input  N  value to load
- `start`  input  1  start from IDLE / resume from PAUSED
- `pause`  input  1  pause while RUN
- `q`  output  N  current count
- `running`  output  1  high in RUN
- `expired`  output  1  high in EXPIRED
- `done`  output  1  one-cycle pulse on terminal decrement

## Operation
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
- Reset (`rst`=0): `q`=0, reload register=0, prescaler=0, state IDLE, `running`=0, `expired`=0, `done`=0. Reset mid-run aborts immediately, with no `done` pulse.
- Priority per cycle: `load` > `pause` > `start`.
- `load` (any state): `q`←`load_val`, reload←`load_val`, prescaler←0, state→IDLE, `done`=0.
- IDLE: `start` with `q`≠0 → RUN and prescaler←0. `start` with `q`=0 is ignored (stays IDLE).
- RUN: the prescaler counts 0..PRESCALE-1 and wraps. Tick = prescaler==PRESCALE-1. On a tick with `q`>1, `q`←`q`-1. On a tick with `q`==1, this is the terminal decrement: `q`←0, `done`←1, state→EXPIRED. `pause` → PAUSED; the prescaler value is held, not cleared. `start` in RUN is ignored.
- PAUSED: everything is frozen. `start` → RUN and counting resumes from the held prescaler value. If `start` and `pause` arrive together, the result is RUN.
- EXPIRED: `q` holds 0. `start` and `pause` are ignored. Only `load` (or reset) exits.
- Pause on the exact tick cycle: `pause` wins and the tick is discarded; the prescaler holds PRESCALE-1, so the decrement fires on the first RUN cycle after resume.
- Arithmetic is unsigned, N bits. `q` never wraps below 0.

## Timing
- All outputs are registered and change only on a `clk` edge (or async reset).
- `start` sampled at edge k: `running` is high after edge k. The first decrement occurs at edge k+PRESCALE.
- Terminal: with `load_val`=V and no pause, `q`=0, `done`=1 and `expired`=1 all appear together after edge k+V·PRESCALE.
- `done` is high for exactly one cycle per terminal decrement.
- Paused cycles add to the latency one-for-one.
- `load` takes effect at the sampling edge; `q` shows `load_val` on the next cycle.

## Configuration
- Macro: `COUNTDOWN_TIMER_AUTO_RELOAD_EN`.
- Defined: on the terminal decrement, `q`←reload register (not 0), `done` pulses, and the state stays RUN with the prescaler wrapping normally. EXPIRED is never entered, so `expired` stays 0. If the reload value is 1, `done` pulses every PRESCALE cycles.
- Undefined: behaviour is as described in Operation (one-shot, ends in EXPIRED).

## Structure
- Package `countdown_timer_pkg`: state typedef (2-bit enum IDLE=0, RUN=1, PAUSED=2, EXPIRED=3) and default parameter constants.
- Sub-module `tick_prescaler`: mod-PRESCALE counter with `en` and synchronous `clr` inputs and a `tick` output (combinational at count==PRESCALE-1). It is instantiated once.
- The FSM and the count register live in the top module.

## Test plan
All scenarios use PRESCALE=4, N=8.
- Load 3, start at edge 0 → `q`=2 at edge 4, 1 at edge 8, 0 at edge 12. `done` is a single pulse at edge 12. `expired`=1 and `running`=0 thereafter.
- Load 3, start, pause at edge 6 for 10 cycles, then resume → terminal at edge 22 with `done` pulsed once. `q` holds 2 throughout the pause.
- Load 5, start, then assert `load` with `load_val`=9 at edge 7 → `q`=9, IDLE, `running`=0, no `done`. A subsequent start counts down from 9.
- Start after reset (`q`=0) → no state change. Assert `rst`=0 mid-RUN → all outputs 0 immediately; the run does not resume after release.
- Start and pause asserted together in PAUSED → RUN. Load and start asserted together → IDLE with `q`=`load_val`.
- With `COUNTDOWN_TIMER_AUTO_RELOAD_EN`: load 2, start → `q` sequence 2,1,2,1… with a `done` pulse every 8 cycles and `expired` never set.
